// File: rtl/rvc_pkg.sv
// rvc_pkg: shared widths, opcode constant and helpers for the RVC fetch aligner
package rvc_pkg;

    localparam int HW_W = 16;
    localparam int INST_W = 32;
    localparam logic [1:0] RVC_OP_FULL = 2'b11;

    function automatic logic is_compressed(input logic [HW_W-1:0] hw);
        return hw[1:0] != RVC_OP_FULL;
    endfunction

endpackage

// File: rtl/rvc_halfword_queue.sv
// rvc_halfword_queue: circular halfword queue with 0..2 push and pop per cycle
module rvc_halfword_queue
    import rvc_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic [1:0]      push_n,
    input  logic [HW_W-1:0] push_hw0,
    input  logic [HW_W-1:0] push_hw1,
    input  logic [1:0]      pop_n,
    output logic [CW-1:0]   count,
    output logic [HW_W-1:0] hw0,
    output logic [HW_W-1:0] hw1
);

    logic [HW_W-1:0] mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("rvc_halfword_queue: DEPTH must be a power of two and at least 4");
    end

    assign hw0 = mem[head];
    assign hw1 = mem[head + PW'(1)];

    // Storage is cleared on reset so the idle head reads as zero; flush only empties the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_n != 2'd0) mem[tail] <= push_hw0;
            if (push_n == 2'd2) mem[tail + PW'(1)] <= push_hw1;
            tail  <= tail + PW'(push_n);
            head  <= head + PW'(pop_n);
            count <= count + CW'(push_n) - CW'(pop_n);
        end
    end

endmodule

// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: repacks word-aligned fetch words into one RVC or RV32 instruction per beat
module rvc_fetch_aligner
    import rvc_pkg::*;
#(
    parameter int XLEN = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid_i,
    output logic              fetch_ready_o,
    input  logic [31:0]       fetch_data_i,
    input  logic              flush_i,
    input  logic [XLEN-1:0]   flush_pc_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] instruction_o,
    output logic              is_rv_o,
    output logic [XLEN-1:0]   inst_pc_o
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [CW-1:0]   count;
    logic [HW_W-1:0] hw0;
    logic [HW_W-1:0] hw1;
    logic [XLEN-1:0] pc_q;
    logic            skip_q;
    logic            push;
    logic            pop;
    logic [1:0]      push_n;
    logic [1:0]      pop_n;
    logic [HW_W-1:0] push_hw0;

    // Handshakes and output formatting from registered queue state only.
    always_comb begin
        is_rv_o       = !is_compressed(hw0);
        inst_valid_o  = is_rv_o ? (count >= CW'(2)) : (count >= CW'(1));
        fetch_ready_o = count <= CW'(BUF_DEPTH - 2);
        instruction_o = is_rv_o ? {hw1, hw0} : {16'h0, hw0};
        inst_pc_o     = pc_q;
        push          = fetch_valid_i && fetch_ready_o && !flush_i;
        pop           = inst_valid_o && inst_ready_i && !flush_i;
        push_n        = push ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
        pop_n         = pop ? (is_rv_o ? 2'd2 : 2'd1) : 2'd0;
        push_hw0      = skip_q ? fetch_data_i[31:16] : fetch_data_i[15:0];
    end

    rvc_halfword_queue #(.DEPTH(BUF_DEPTH)) u_queue (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush_i),
        .push_n   (push_n),
        .push_hw0 (push_hw0),
        .push_hw1 (fetch_data_i[31:16]),
        .pop_n    (pop_n),
        .count    (count),
        .hw0      (hw0),
        .hw1      (hw1)
    );

    // Head PC advances with each pop; a redirect reloads it and arms dropping of the low half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            skip_q <= RESET_PC[1];
        end else if (flush_i) begin
            pc_q   <= flush_pc_i;
            skip_q <= flush_pc_i[1];
        end else begin
            if (pop) pc_q <= pc_q + (is_rv_o ? XLEN'(4) : XLEN'(2));
            if (push) skip_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// tb_rvc_fetch_aligner: scoreboard bench for the RVC fetch aligner
module tb_rvc_fetch_aligner;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    typedef struct {
        logic [31:0] inst;
        logic        rv;
        logic [63:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic [31:0] fetch_data_i = '0;
    logic        flush_i = 1'b0;
    logic [63:0] flush_pc_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] instruction_o;
    logic        is_rv_o;
    logic [63:0] inst_pc_o;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    rvc_fetch_aligner dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .fetch_data_i  (fetch_data_i),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .instruction_o (instruction_o),
        .is_rv_o       (is_rv_o),
        .inst_pc_o     (inst_pc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && inst_valid_o && inst_ready_i && !flush_i) begin
            if (sb.size() == 0) begin
                chk("extra_valid", {63'b0, inst_valid_o}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("inst", {32'b0, instruction_o}, {32'b0, e.inst});
                chk("is_rv", {63'b0, is_rv_o}, {63'b0, e.rv});
                chk("pc", inst_pc_o, e.pc);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_inst(input logic [31:0] inst, input logic rv, input logic [63:0] pc);
        exp_t e;
        e.inst = inst;
        e.rv   = rv;
        e.pc   = pc;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fetch_valid_i = 1'b0;
        inst_ready_i = 1'b0;
        flush_i = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        logic done;
        done = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_data_i = w;
        for (int i = 0; i < 50 && !done; i++) begin
            done = fetch_ready_o;
            cyc();
        end
        fetch_valid_i = 1'b0;
        chk("push_accept", {63'b0, done}, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) cyc();
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        do_reset();
        chk("rst_valid", {63'b0, inst_valid_o}, 64'd0);
        chk("rst_ready", {63'b0, fetch_ready_o}, 64'd1);
        chk("rst_inst", {32'b0, instruction_o}, 64'd0);
        chk("rst_is_rv", {63'b0, is_rv_o}, 64'd0);
        chk("rst_pc", inst_pc_o, RST_PC);

        // straight 32-bit
        inst_ready_i = 1'b1;
        expect_inst(32'h00500093, 1'b1, RST_PC);
        push_word(32'h00500093);
        chk("t1_latency", {63'b0, inst_valid_o}, 64'd1);
        drain();
        chk("t1_empty", {63'b0, inst_valid_o}, 64'd0);

        // two compressed in one word
        do_reset();
        inst_ready_i = 1'b1;
        expect_inst(32'h00000085, 1'b0, RST_PC);
        expect_inst(32'h00004505, 1'b0, RST_PC + 64'd2);
        push_word(32'h45050085);
        drain();
        chk("t2_empty", {63'b0, inst_valid_o}, 64'd0);

        // straddling 32-bit instruction
        do_reset();
        inst_ready_i = 1'b1;
        expect_inst(32'h00000001, 1'b0, RST_PC);
        expect_inst(32'h00500093, 1'b1, RST_PC + 64'd2);
        expect_inst(32'h00004505, 1'b0, RST_PC + 64'd6);
        push_word(32'h00930001);
        cyc();
        chk("t3_half_wait", {63'b0, inst_valid_o}, 64'd0);
        chk("t3_half_pc", inst_pc_o, RST_PC + 64'd2);
        push_word(32'h45050050);
        drain();
        chk("t3_empty", {63'b0, inst_valid_o}, 64'd0);

        // misaligned redirect with 3 halfwords buffered
        do_reset();
        push_word(32'h00930001);
        push_word(32'h45050050);
        expect_inst(32'h00000001, 1'b0, RST_PC);
        inst_ready_i = 1'b1;
        cyc();
        inst_ready_i = 1'b0;
        drain();
        flush_i = 1'b1;
        flush_pc_i = 64'h0000_0000_8000_0102;
        fetch_valid_i = 1'b1;
        fetch_data_i = 32'hDEADBEEF;
        inst_ready_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        fetch_valid_i = 1'b0;
        chk("t4_flush_valid", {63'b0, inst_valid_o}, 64'd0);
        chk("t4_flush_pc", inst_pc_o, 64'h0000_0000_8000_0102);
        chk("t4_flush_ready", {63'b0, fetch_ready_o}, 64'd1);
        expect_inst(32'h00000085, 1'b0, 64'h0000_0000_8000_0102);
        push_word(32'h0085FFFF);
        drain();
        chk("t4_empty", {63'b0, inst_valid_o}, 64'd0);

        // backpressure
        do_reset();
        expect_inst(32'h00500093, 1'b1, RST_PC);
        expect_inst(32'h00000085, 1'b0, RST_PC + 64'd4);
        expect_inst(32'h00004505, 1'b0, RST_PC + 64'd6);
        expect_inst(32'h00A00113, 1'b1, RST_PC + 64'd8);
        push_word(32'h00500093);
        push_word(32'h45050085);
        chk("t5_full_ready", {63'b0, fetch_ready_o}, 64'd0);
        fetch_valid_i = 1'b1;
        fetch_data_i = 32'h00A00113;
        repeat (2) cyc();
        chk("t5_held_ready", {63'b0, fetch_ready_o}, 64'd0);
        chk("t5_held_head", {32'b0, instruction_o}, 64'h00500093);
        inst_ready_i = 1'b1;
        push_word(32'h00A00113);
        drain();
        chk("t5_empty", {63'b0, inst_valid_o}, 64'd0);

        // async reset mid-stream with 3 halfwords buffered
        do_reset();
        push_word(32'h00930001);
        push_word(32'h45050050);
        expect_inst(32'h00000001, 1'b0, RST_PC);
        inst_ready_i = 1'b1;
        cyc();
        inst_ready_i = 1'b0;
        drain();
        chk("t6_pre_pc", inst_pc_o, RST_PC + 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_arst_valid", {63'b0, inst_valid_o}, 64'd0);
        chk("t6_arst_ready", {63'b0, fetch_ready_o}, 64'd1);
        chk("t6_arst_pc", inst_pc_o, RST_PC);
        chk("t6_arst_inst", {32'b0, instruction_o}, 64'd0);
        cyc();
        rst = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
